whole_operation: RTL and testbench



---
 rtl/whole_operation.sv | 86 ++++++++
 tb/tb_whole_operation.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/whole_operation.sv
// whole_operation: 32-bit registered carry-select adder.
// {cout, sum} = x + y + cin, presented one clock after the operands are sampled.
// Datapath: eight 4-bit slices; slice 0 ripples from cin, slices 1-7 compute
// both carry-in cases and a 2:1 mux picks one using the previous slice's carry.
module whole_operation (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic        cout,
    output logic [31:0] sum
);

    localparam int SLICE_W  = 4;
    localparam int N_SLICES = 8;

    // 4-bit ripple-carry adder built from a chain of full adders.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [SLICE_W:0] ripple4(
        input logic [SLICE_W-1:0] a,
        input logic [SLICE_W-1:0] b,
        input logic               c_in
    );
        logic [SLICE_W-1:0] s;
        logic               c;
        c = c_in;
        for (int k = 0; k < SLICE_W; k++) begin
            s[k] = a[k] ^ b[k] ^ c;
            c    = (a[k] & b[k]) | (a[k] & c) | (b[k] & c);
        end
        return {c, s};
    endfunction

    // Per-slice results for both carry-in assumptions, plus the selected carry.
    logic [SLICE_W:0]   slice_c0  [N_SLICES];
    logic [SLICE_W:0]   slice_c1  [N_SLICES];
    logic [N_SLICES:0]  carry_sel;
    logic [31:0]        sum_d;
    logic               cout_d;
    logic [31:0]        sum_q;
    logic               cout_q;

    // Speculative slice sums: both carry-in cases computed in parallel so the
    // only serial path through slices 1-7 is the select mux chain.
    always_comb begin
        for (int i = 0; i < N_SLICES; i++) begin
            slice_c0[i] = ripple4(x[i*SLICE_W +: SLICE_W], y[i*SLICE_W +: SLICE_W], 1'b0);
            slice_c1[i] = ripple4(x[i*SLICE_W +: SLICE_W], y[i*SLICE_W +: SLICE_W], 1'b1);
        end
    end

    // Carry-select chain: slice 0 uses the real cin, each later slice muxes
    // its precomputed result on the incoming selected carry.
    always_comb begin
        sum_d        = '0;
        carry_sel    = '0;
        carry_sel[0] = cin;
        for (int i = 0; i < N_SLICES; i++) begin
            if (carry_sel[i]) begin
                sum_d[i*SLICE_W +: SLICE_W] = slice_c1[i][SLICE_W-1:0];
                carry_sel[i+1]              = slice_c1[i][SLICE_W];
            end else begin
                sum_d[i*SLICE_W +: SLICE_W] = slice_c0[i][SLICE_W-1:0];
                carry_sel[i+1]              = slice_c0[i][SLICE_W];
            end
        end
        cout_d = carry_sel[N_SLICES];
    end

    // Output register: captures the 33-bit result every cycle; cleared
    // asynchronously so outputs read zero the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_whole_operation.sv
// Self-checking bench for whole_operation: directed table, reset sequences,
// and randomized operands against an arithmetic reference.
module tb_whole_operation;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        cout;
    logic [31:0] sum;

    int total_checks;
    int passed_checks;

    whole_operation dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .cin   (cin),
        .cout  (cout),
        .sum   (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] exp_sum, input logic exp_cout);
        total_checks++;
        if (sum === exp_sum && cout === exp_cout) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got sum=0x%08h cout=%0b, expected sum=0x%08h cout=%0b",
                     name, sum, cout, exp_sum, exp_cout);
        end
    endtask

    // Drive operands mid-cycle, then sample just after the capturing edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        x   = a;
        y   = b;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic, split into 33-bit result.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        longint unsigned r;
        r = longint'(a) + longint'(b) + longint'(c);
        return r[32:0];
    endfunction

    initial begin
        logic [32:0] r;
        total_checks  = 0;
        passed_checks = 0;

        vecs.push_back('{32'hFFFF_FFFF, 32'd34,        1'b1, 32'd34,         1'b1, "wrap_y34_cin1"});
        vecs.push_back('{32'hFFFF_FFFF, 32'd54,        1'b0, 32'd53,         1'b1, "wrap_y54_cin0"});
        vecs.push_back('{32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000,  1'b0, "msb_carry"});
        vecs.push_back('{32'd16383,     32'd1,         1'b0, 32'd16384,      1'b0, "slice_carry_16383"});
        vecs.push_back('{32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0,          1'b1, "full_wrap_cin"});
        vecs.push_back('{32'd4234234,   32'd432,       1'b0, 32'd4234666,    1'b0, "b2b_0"});
        vecs.push_back('{32'd855,       32'd100,       1'b0, 32'd955,        1'b0, "b2b_1"});
        vecs.push_back('{32'd423434524, 32'd532523523, 1'b1, 32'd955958048,  1'b0, "b2b_2"});
        vecs.push_back('{32'd22,        32'd3,         1'b1, 32'd26,         1'b0, "b2b_3"});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF,  1'b1, "max_all"});
        vecs.push_back('{32'd0,         32'd0,         1'b0, 32'd0,          1'b0, "zero"});

        // Reset held with nonzero operands while clock toggles.
        rst_n = 1'b0;
        x     = 32'd10;
        y     = 32'd11;
        cin   = 1'b1;
        #1;
        check("reset_initial", 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", 32'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 32'd22, 1'b0);

        // Directed table, applied on consecutive cycles.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].x, vecs[i].y, vecs[i].cin);
            check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Asynchronous reset asserted between edges with nonzero outputs.
        apply(32'hFFFF_FFFF, 32'd5, 1'b0);
        check("pre_async", 32'd4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        x     = 32'd1000;
        y     = 32'd2000;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        check("after_async_resume", 32'd3001, 1'b0);

        // Operands changing between edges are not visible until the next edge.
        @(negedge clk);
        x = 32'd7;
        y = 32'd8;
        cin = 1'b0;
        #2;
        check("hold_between_edges", 32'd3001, 1'b0);
        @(posedge clk);
        #1;
        check("hold_then_update", 32'd15, 1'b0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        c;
            a = $urandom();
            b = $urandom();
            c = 1'($urandom_range(0, 1));
            apply(a, b, c);
            r = ref_add(a, b, c);
            check("random", r[31:0], r[32]);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
